// File: rtl/uart_pkg.sv
// Shared UART register types and the receive-engine state enum.
// Field layouts follow the 16550 register map, MSB first.
package uart_pkg;

  typedef logic [15:0] div_t;

  typedef struct packed {
    logic       dlab;
    logic       set_break;
    logic       stick_parity;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef struct packed {
    logic [1:0] rx_trig;
    logic [1:0] rsvd;
    logic       dma_mode;
    logic       tx_rst;
    logic       rx_rst;
    logic       fifo_en;
  } fcr_t;

  typedef struct packed {
    logic rx_fifo_err;
    logic temt;
    logic thre;
    logic bi;
    logic fe;
    logic pe;
    logic oe;
    logic dr;
  } lsr_t;

  typedef struct packed {
    lcr_t lcr;
    fcr_t fcr;
    div_t div;
  } csr_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  // Parity bit a correct transmitter would send; data must already be zero above the word length.
  function automatic logic rx_exp_parity(input logic stick, input logic eps, input logic [7:0] data);
    logic p;
    if (stick) begin
      p = ~eps;
    end else if (eps) begin
      p = ^data;
    end else begin
      p = ~^data;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Per-character result bus from the receive engine toward the RX FIFO.
// push is a one-cycle strobe; data and flags hold between pushes.
interface uart_rx_if;
  logic       push;
  logic [7:0] data;
  logic       pe;
  logic       fe;
  logic       bi;

  modport master (output push, data, pe, fe, bi);
  modport slave  (input  push, data, pe, fe, bi);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; reset value selects the idle level.
// Latency 2 clk; no backpressure.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receive deframer: 16x oversampled start/data/parity/stop, one push per character.
// push rises the clk after the stop-bit sample tick; no backpressure (overrun handled by the FIFO).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      baud_pulse,
  input  logic      rx,
  input  lcr_t      lcr_i,
  uart_rx_if.master rx_if
);

  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  rx_state_t  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  lcr_t       lcr_q, lcr_d;
  logic       push_q, push_d;
  logic [7:0] data_q, data_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       bi_q, bi_d;

  logic [2:0] last_bit;
  logic       mid_bit;
  logic       stop_fe;

  assign last_bit = 3'd4 + {1'b0, lcr_q.wls};
  assign mid_bit  = (tick_q == TICK_LAST);
  assign stop_fe  = ~rx_s;

  // Frame format fields that only matter to the transmitter or register block.
  logic unused_lcr;
  assign unused_lcr = ^{lcr_q.stb, lcr_q.set_break, lcr_q.dlab};

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    lcr_d   = lcr_q;
    push_d  = 1'b0;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    bi_d    = bi_q;

    if (baud_pulse) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = 4'd0;
            lcr_d   = lcr_i;
            shreg_d = 8'h00;
            par_d   = 1'b0;
          end
        end

        START: begin
          if (tick_q == TICK_MID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tick_d  = 4'd0;
              bit_d   = 3'd0;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end

        DATA: begin
          tick_d = tick_q + 4'd1;
          if (mid_bit) begin
            shreg_d[bit_q] = rx_s;
            bit_d          = bit_q + 3'd1;
            if (bit_q == last_bit) begin
              state_d = lcr_q.pen ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          tick_d = tick_q + 4'd1;
          if (mid_bit) begin
            par_d   = rx_s;
            state_d = STOP;
          end
        end

        STOP: begin
          tick_d = tick_q + 4'd1;
          if (mid_bit) begin
            push_d  = 1'b1;
            data_d  = shreg_q;
            pe_d    = lcr_q.pen &
                      (par_q != rx_exp_parity(lcr_q.stick_parity, lcr_q.eps, shreg_q));
            fe_d    = stop_fe;
            bi_d    = (shreg_q == 8'h00) & (~par_q | ~lcr_q.pen) & stop_fe;
            // A low stop bit parks here so a long break yields a single push.
            state_d = rx_s ? IDLE : BRK_WAIT;
          end
        end

        BRK_WAIT: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      par_q   <= 1'b0;
      lcr_q   <= '0;
      push_q  <= 1'b0;
      data_q  <= 8'h00;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      lcr_q   <= lcr_d;
      push_q  <= push_d;
      data_q  <= data_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      bi_q    <= bi_d;
    end
  end

  assign rx_if.push = push_q;
  assign rx_if.data = data_q;
  assign rx_if.pe   = pe_q;
  assign rx_if.fe   = fe_q;
  assign rx_if.bi   = bi_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: line-level frame model with a scoreboard queue checked on every cycle.
module tb_uart_rx;

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic       baud_pulse = 1'b0;
  logic       baud_en    = 1'b1;
  logic       rx         = 1'b1;
  logic [7:0] lcr_i      = 8'h03;

  uart_rx_if rx_if ();

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_pulse (baud_pulse),
    .rx         (rx),
    .lcr_i      (lcr_i),
    .rx_if      (rx_if)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  exp_t exp_q[$];
  int   push_cyc[$];
  int   cyc = 0;
  int   frame_start = 0;
  int   errors = 0;
  int   checks = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end
  // Divisor 1: a tick on every other clk.
  initial forever begin
    @(posedge clk);
    #1 baud_pulse = baud_en ? ~baud_pulse : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (baud_pulse !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic b);
    #1 rx = b;
    wait_ticks(16);
  endtask

  // Parity bit a correct transmitter sends, by counting ones.
  function automatic logic model_par(input logic [7:0] lcr, input logic [7:0] d);
    int n;
    int ones;
    n    = 5 + int'(lcr[1:0]);
    ones = 0;
    for (int i = 0; i < n; i++) ones = ones + int'(d[i]);
    if (lcr[5]) return !lcr[4];
    if (lcr[4]) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  task automatic send_char(input logic [7:0] lcr, input logic [7:0] d, input logic bad_par,
                           input logic stop, input logic scramble);
    int         n;
    logic [7:0] dm;
    logic       par;
    exp_t       e;
    n   = 5 + int'(lcr[1:0]);
    dm  = 8'h00;
    for (int i = 0; i < n; i++) dm[i] = d[i];
    par  = model_par(lcr, dm) ^ bad_par;
    e.d  = dm;
    e.pe = lcr[3] & bad_par;
    e.fe = !stop;
    e.bi = (dm == 8'h00) && (!lcr[3] || !par) && !stop;
    exp_q.push_back(e);
    lcr_i = lcr;
    #1 rx = 1'b0;
    frame_start = cyc;
    wait_ticks(16);
    if (scramble) lcr_i = ~lcr;
    for (int i = 0; i < n; i++) drive_bit(dm[i]);
    if (lcr[3]) drive_bit(par);
    drive_bit(stop);
    lcr_i = lcr;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic chk_out(input string name, input logic [7:0] d, input logic pe, input logic fe,
                         input logic bi);
    #2;
    chk({name, "_data"}, rx_if.data, d);
    chk({name, "_flags"}, {rx_if.pe, rx_if.fe, rx_if.bi}, {pe, fe, bi});
  endtask

  // Scoreboard: every push must match the next expected character; outputs hold otherwise.
  initial begin : cmp
    exp_t e;
    exp_t last;
    logic prev_push;
    last      = '0;
    prev_push = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last      = '0;
        prev_push = 1'b0;
      end else begin
        if (rx_if.push) begin
          chk("push_width", prev_push, 1'b0);
          push_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_push", {rx_if.data, rx_if.pe, rx_if.fe, rx_if.bi}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("push_data", rx_if.data, e.d);
            chk("push_pe", rx_if.pe, e.pe);
            chk("push_fe", rx_if.fe, e.fe);
            chk("push_bi", rx_if.bi, e.bi);
            last = e;
          end
        end else begin
          chk("hold", {rx_if.data, rx_if.pe, rx_if.fe, rx_if.bi}, last);
        end
        prev_push = rx_if.push;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    int s1;
    exp_t brk;

    // Pin the parity model with hand-worked cases.
    chk("model_7E1_41", model_par(8'h1A, 8'h41), 1'b0);
    chk("model_8O1_55", model_par(8'h0B, 8'h55), 1'b1);
    chk("model_stick_e", model_par(8'h3B, 8'h01), 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_push", rx_if.push, 1'b0);
    chk("rst_out", {rx_if.data, rx_if.pe, rx_if.fe, rx_if.bi}, 11'h000);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_ticks(1);
    idle_bits(4);

    // 8N1 back-to-back; LCR scrambled mid-frame on the second character.
    n0 = push_cyc.size();
    send_char(8'h03, 8'h55, 1'b0, 1'b1, 1'b0);
    s1 = frame_start;
    send_char(8'h03, 8'hA3, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    chk("b2b_count", push_cyc.size() - n0, 2);
    if (push_cyc.size() - n0 == 2) begin
      chk("b2b_latency", push_cyc[n0] - s1, 308);
      chk("b2b_spacing", push_cyc[n0+1] - push_cyc[n0], 320);
    end
    chk_out("b2b", 8'hA3, 1'b0, 1'b0, 1'b0);

    // 7E1 parity wrong, then right.
    send_char(8'h1A, 8'h41, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    chk_out("pe_bad", 8'h41, 1'b1, 1'b0, 1'b0);
    send_char(8'h1A, 8'h41, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    chk_out("pe_good", 8'h41, 1'b0, 1'b0, 1'b0);

    // Framing error, then a normal frame proves the engine left BRK_WAIT.
    send_char(8'h03, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle_bits(3);
    chk_out("fe", 8'h3C, 1'b0, 1'b1, 1'b0);
    send_char(8'h03, 8'h5A, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    chk_out("after_fe", 8'h5A, 1'b0, 1'b0, 1'b0);

    // Long break: one push only.
    lcr_i = 8'h03;
    brk   = {8'h00, 1'b0, 1'b1, 1'b1};
    exp_q.push_back(brk);
    n0 = push_cyc.size();
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    idle_bits(2);
    chk("brk_count", push_cyc.size() - n0, 1);
    chk_out("brk", 8'h00, 1'b0, 1'b1, 1'b1);
    send_char(8'h03, 8'h81, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    chk_out("after_brk", 8'h81, 1'b0, 1'b0, 1'b0);

    // 5N1 then a 4-tick glitch.
    send_char(8'h00, 8'h1F, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    chk_out("5n1", 8'h1F, 1'b0, 1'b0, 1'b0);
    n0 = push_cyc.size();
    #1 rx = 1'b0;
    wait_ticks(4);
    #1 rx = 1'b1;
    wait_ticks(32);
    chk("glitch_count", push_cyc.size() - n0, 0);

    // Reset in the middle of DATA.
    lcr_i = 8'h03;
    n0 = push_cyc.size();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    #1 rx = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", {rx_if.push, rx_if.data, rx_if.pe, rx_if.fe, rx_if.bi}, 12'h000);
    wait_ticks(1);
    idle_bits(2);
    send_char(8'h03, 8'h99, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    chk("midrst_count", push_cyc.size() - n0, 1);
    chk_out("midrst", 8'h99, 1'b0, 1'b0, 1'b0);

    // Baud tick stuck low: line activity must not produce a push.
    n0 = push_cyc.size();
    baud_en = 1'b0;
    #1 rx = 1'b0;
    repeat (200) @(posedge clk);
    #1 rx = 1'b1;
    repeat (50) @(posedge clk);
    baud_en = 1'b1;
    wait_ticks(40);
    chk("stuck_count", push_cyc.size() - n0, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive engine of the 16550-style UART. It oversamples the `rx` line using the shared 16x baud tick from the register/baud block and deframes characters according to the current LCR. For each character it pushes one byte plus per-character error flags toward the RX FIFO. The RX FIFO's empty flag and error flags feed back into the LSR.

## Interface
Parameters:
- `OVERSAMPLE`, 16: baud ticks per bit. Fixed at 16; the tick counter is 4 bits.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-low (`rst`=0 at posedge `clk` resets).
- `baud_pulse`  in  1  one-`clk` tick at 16x bit rate (register block's `baud_out`).
- `rx`  in  1  asynchronous serial input; idle high.
- `lcr_i`  in  8  `lcr_t`: `wls`, `stb`, `pen`, `eps`, `stick_parity`, `set_break`, `dlab`.
- `push_o`  out  1  one-cycle strobe: character complete; write `data_o` and flags into the RX FIFO.
- `data_o`  out  8  received character, LSB-first assembled, zero-extended above the word length.
- `pe_o`  out  1  parity error; valid with `push_o`.
- `fe_o`  out  1  framing error (stop bit sampled 0); valid with `push_o`.
- `bi_o`  out  1  break: all data bits, parity (if enabled) and stop sampled 0; valid with `push_o`.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- State (`rx_state_t`): IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- Counters: `tick_cnt` 4-bit and `bit_cnt` 3-bit. Both change only on `baud_pulse`.
- IDLE: on a `baud_pulse` with `rx_s`=0, go to START and set `tick_cnt`=0. `lcr_i` is latched into `lcr_q` at this point and used for the whole frame, so LCR writes mid-frame do not affect the frame in progress.
- START: on the tick where `tick_cnt`==7 (mid start bit), sample the line.
  - `rx_s`=1: false start; return to IDLE with no push.
  - `rx_s`=0: clear `tick_cnt` and `bit_cnt`; go to DATA.
- DATA: sample on each tick where `tick_cnt`==15, which is mid-bit.
  - Shift the sample into `shreg[bit_cnt]` and increment `bit_cnt`.
  - The word length is 5+`wls`. After the last bit, go to PARITY if `pen`=1, else STOP.
- PARITY: sample at `tick_cnt`==15. Expected parity:
  - `stick_parity`=1: expected = ~`eps`.
  - Otherwise: `eps`=1 (even) gives ^data; `eps`=0 (odd) gives ~^data.
  - `pe` = sampled != expected.
- STOP: sample at `tick_cnt`==15. Only one stop bit is checked regardless of `stb`.
  - `fe` = ~`rx_s`.
  - `bi` = (data==0) & (parity sample==0 or `pen`=0) & `fe`.
  - Assert `push_o` with `data_o`, `pe_o`, `fe_o`, `bi_o`.
  - Next state: `rx_s`=1 gives IDLE; `rx_s`=0 gives BRK_WAIT.
- BRK_WAIT: stay until a `baud_pulse` with `rx_s`=1, then go to IDLE. Exactly one push is made per break, no matter how long the break lasts.
- The overrun error (`oe`) is not generated here; the RX FIFO derives it from a `push_o` while full.

## Timing
- Reset values:
  - `push_o`=0, `data_o`=0, `pe_o`=`fe_o`=`bi_o`=0.
  - State IDLE, counters 0, synchronizer flops 1.
- Reset mid-frame: return to IDLE next clock with no push. The partial character is discarded.
- Input latency: 2 `clk` (synchronizer) plus up to 1 baud tick of start-detect jitter.
- `push_o` is registered and rises on the `clk` after the `baud_pulse` that samples the stop bit. It is high for exactly 1 cycle.
- `data_o` and the flags hold their values until the next push.
- Frame length in ticks: 8 (start to mid) + 16×(word bits + parity bit if enabled) + 16 (stop), measured from the start-detect tick.
- Fewer than 8 consecutive low ticks on a start bit are rejected as a false start.
- `baud_pulse` stuck at 0 (divisor 0): the FSM freezes and no pushes occur.
- `tick_cnt` wraps from 15 to 0 inside DATA and PARITY; it is cleared to 0 on entry to DATA.

## Structure
- Shared package `uart_pkg` holds `fcr_t`, `lcr_t`, `lsr_t`, `csr_t`, `div_t` (moved out of the register block) plus the new `rx_state_t` enum.
- Sub-module `uart_sync2`: 2-flop synchronizer with a reset-value parameter. It is reused for the CTS/DSR inputs later.

## Test plan
All scenarios use divisor 1 (`baud_pulse` every other `clk`) unless stated.

- LCR 0x03 (8N1), send 0x55 then 0xA3 back-to-back → two pushes, `data_o` 0x55 then 0xA3, all flags 0; push spacing 160 ticks.
- LCR 0x1A (7E1), send 0x41 with parity bit 1 (wrong) → `data_o` 0x41, `pe_o`=1, `fe_o`=0. Repeat with a correct parity bit → `pe_o`=0.
- LCR 0x03, send 0x3C with stop bit 0, then line high → `data_o` 0x3C, `fe_o`=1, `bi_o`=0, FSM returns to IDLE via BRK_WAIT.
- LCR 0x03, hold `rx` low for 40 bit times → exactly one push: `data_o` 0x00, `fe_o`=1, `bi_o`=1. The next valid 0x81 frame is received correctly.
- LCR 0x00 (5N1), send 0x1F; then pulse `rx` low for only 4 ticks → `data_o` 0x1F with upper bits 0; the glitch produces no push.
- LCR 0x03, assert `rst`=0 mid-DATA, release, send 0x99 → no push for the partial frame; next push is 0x99 with flags 0.
